// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg -- shared core-wide constants.
//   DEFAULT_XLEN : default PC / address width
//   INST_NOP     : canonical NOP (addi x0, x0, 0)
//   PC_STEP      : byte distance between sequential instructions
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int          DEFAULT_XLEN = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam int          PC_STEP      = 4;

endpackage : core_pkg

// File: rtl/inst_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue_if -- fetch-side and decode-side handshakes of the
// instruction fetch queue.
//   memory_i_addr / memory_i_valid : fetch request (queue -> memory)
//   memory_i_ready / memory_inst   : accept + same-cycle instruction data
//   id_valid / id_inst / id_reg_pc : queue head offered to decode
//   id_ready                       : decode accepts the head
// Modports: master = fetch queue, slave = memory + decode environment.
// ---------------------------------------------------------------------------
interface inst_fetch_queue_if #(
  parameter int XLEN = core_pkg::DEFAULT_XLEN
);

  logic [XLEN-1:0] memory_i_addr;
  logic            memory_i_valid;
  logic            memory_i_ready;
  logic [31:0]     memory_inst;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_reg_pc;

  modport master (
    output memory_i_addr, memory_i_valid, id_valid, id_inst, id_reg_pc,
    input  memory_i_ready, memory_inst, id_ready
  );

  modport slave (
    input  memory_i_addr, memory_i_valid, id_valid, id_inst, id_reg_pc,
    output memory_i_ready, memory_inst, id_ready
  );

endinterface : inst_fetch_queue_if

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo -- circular FIFO holding {pc, instruction} entries.
//   clk, reset : clock, synchronous active-high reset
//   flush      : drop every entry (pointers and count to 0)
//   push/wdata : write one entry; ignored when full
//   pop        : retire the head; ignored when empty
//   rdata      : head entry (asynchronous read of small register storage so
//                the head is visible the cycle after it is written)
//   empty/full/count : status
// DEPTH must be a power of two so pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok, pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule : ifq_fifo

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue -- sequential instruction fetcher with a small decoupling
// queue between instruction memory and decode.
//   clk, reset : clock, synchronous active-high reset
//   bus        : inst_fetch_queue_if.master (memory fetch + decode handshakes)
//   br_flg     : redirect from execute (flushes queue, highest priority)
//   br_target  : redirect address (word aligned internally)
//   occupancy  : entries currently queued
// Build option: define IFQ_BYPASS_EN to let a fetch response reach decode in
// the same cycle while the queue is empty.
// ---------------------------------------------------------------------------
module inst_fetch_queue
  import core_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       reset,
  inst_fetch_queue_if.master         bus,
  input  logic                       br_flg,
  input  logic [XLEN-1:0]            br_target,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int ENTRY_W = XLEN + 32;

  logic [XLEN-1:0]    fetch_pc_reg, fetch_pc_next;
  logic               fetch_fire;
  logic               fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic               bypass_take;
  logic [ENTRY_W-1:0] head_entry;
  logic [XLEN-1:0]    head_pc;
  logic [31:0]        head_inst;

  assign {head_pc, head_inst} = head_entry;

  // Fetch request: the redirect gates it combinationally so a stale-path
  // fetch is never accepted in the redirect cycle.
  assign bus.memory_i_addr  = fetch_pc_reg;
  assign bus.memory_i_valid = !reset && !fifo_full && !br_flg;
  assign fetch_fire         = bus.memory_i_valid && bus.memory_i_ready;

  // Decode-side view of the head.
  always_comb begin
    bus.id_valid  = 1'b0;
    bus.id_inst   = INST_NOP;
    bus.id_reg_pc = head_pc;
    bypass_take   = 1'b0;
    if (reset) begin
      bus.id_reg_pc = RESET_PC;
    end else if (!fifo_empty) begin
      bus.id_valid = 1'b1;
      bus.id_inst  = head_inst;
`ifdef IFQ_BYPASS_EN
    end else if (fetch_fire) begin
      // Empty queue: hand the response straight to decode; it is written
      // into the queue only if decode does not take it this cycle.
      bus.id_valid  = 1'b1;
      bus.id_inst   = bus.memory_inst;
      bus.id_reg_pc = fetch_pc_reg;
      bypass_take   = bus.id_ready;
`endif
    end
  end

  // A redirect discards any pop in the same cycle (the flush wins anyway).
  assign fifo_pop  = !br_flg && !fifo_empty && bus.id_ready;
  assign fifo_push = fetch_fire && !bypass_take;

  ifq_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (br_flg),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({fetch_pc_reg, bus.memory_inst}),
    .rdata (head_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (occupancy)
  );

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (br_flg) begin
      fetch_pc_next = br_target & ~XLEN'(3);
    end else if (fetch_fire) begin
      fetch_pc_next = fetch_pc_reg + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

endmodule : inst_fetch_queue

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue -- directed self-checking bench for inst_fetch_queue
// (DEPTH=4, XLEN=32, RESET_PC=0). Inputs change 1 time unit after the rising
// edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;
  import core_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             br_flg;
  logic [XLEN-1:0]  br_target;
  logic [OCC_W-1:0] occupancy;
  int               check_count = 0;
  int               pass_count  = 0;

  inst_fetch_queue_if #(.XLEN(XLEN)) bus ();

  inst_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .br_flg    (br_flg),
    .br_target (br_target),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory: a fixed, address-dependent pattern.
  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    return (addr << 1) ^ 32'hC0DE_0013;
  endfunction

  assign bus.memory_inst = mem_model(bus.memory_i_addr);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      pass_count++;
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [31:0] exp_pc;

  initial begin
    // Reset with handshakes and a redirect asserted: reset must win.
    reset               = 1'b1;
    br_flg              = 1'b1;
    br_target           = 32'h0000_0500;
    bus.memory_i_ready  = 1'b1;
    bus.id_ready        = 1'b1;
    tick();
    tick();
    settle();
    check_eq("rst_mem_valid", 64'(bus.memory_i_valid), 64'd0);
    check_eq("rst_id_valid",  64'(bus.id_valid), 64'd0);
    check_eq("rst_id_inst",   64'(bus.id_inst), 64'(INST_NOP));
    check_eq("rst_id_pc",     64'(bus.id_reg_pc), 64'h0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);

`ifndef IFQ_BYPASS_EN
    // Streaming: first request right after reset, decode sees 0,4,8.
    reset  = 1'b0;
    br_flg = 1'b0;
    settle();
    check_eq("first_req_valid", 64'(bus.memory_i_valid), 64'd1);
    check_eq("first_req_addr",  64'(bus.memory_i_addr), 64'h0);
    check_eq("first_id_valid",  64'(bus.id_valid), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("stream_valid", 64'(bus.id_valid), 64'd1);
      check_eq("stream_pc",    64'(bus.id_reg_pc), 64'(i * 4));
      check_eq("stream_inst",  64'(bus.id_inst), 64'(mem_model(32'(i * 4))));
      tick();
    end

    // Decode stalled: queue saturates, head stays at PC 0.
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    bus.id_ready = 1'b0;
    repeat (10) tick();
    settle();
    check_eq("sat_occupancy", 64'(occupancy), 64'd4);
    check_eq("sat_mem_valid", 64'(bus.memory_i_valid), 64'd0);
    check_eq("sat_head_pc",   64'(bus.id_reg_pc), 64'h0);
    check_eq("sat_id_valid",  64'(bus.id_valid), 64'd1);
    check_eq("sat_addr",      64'(bus.memory_i_addr), 64'h10);

    // Pop at full: no push that cycle (one bubble), then refill.
    bus.id_ready = 1'b1;
    settle();
    check_eq("bubble_mem_valid", 64'(bus.memory_i_valid), 64'd0);
    tick();
    bus.id_ready = 1'b0;
    settle();
    check_eq("bubble_occupancy", 64'(occupancy), 64'd3);
    check_eq("bubble_head_pc",   64'(bus.id_reg_pc), 64'h4);
    tick();
    settle();
    check_eq("refill_occupancy", 64'(occupancy), 64'd4);

    // Redirect from a full queue to an unaligned target.
    br_flg       = 1'b1;
    br_target    = 32'h0000_0103;
    bus.id_ready = 1'b1;
    settle();
    check_eq("br_mem_valid", 64'(bus.memory_i_valid), 64'd0);
    tick();
    br_flg = 1'b0;
    settle();
    check_eq("br_occupancy",     64'(occupancy), 64'd0);
    check_eq("br_id_valid",      64'(bus.id_valid), 64'd0);
    check_eq("br_id_inst",       64'(bus.id_inst), 64'(INST_NOP));
    check_eq("br_addr",          64'(bus.memory_i_addr), 64'h100);
    check_eq("br_next_mem_valid", 64'(bus.memory_i_valid), 64'd1);
    tick();
    settle();
    check_eq("br_target_valid", 64'(bus.id_valid), 64'd1);
    check_eq("br_target_pc",    64'(bus.id_reg_pc), 64'h100);

    // memory_i_ready toggling: decode must see 0x200..0x20C exactly once.
    br_flg    = 1'b1;
    br_target = 32'h0000_0200;
    tick();
    br_flg = 1'b0;
    exp_pc = 32'h0000_0200;
    for (int k = 0; k < 9; k++) begin
      bus.memory_i_ready = ((k % 2) == 0) && (k < 8);
      settle();
      if (bus.id_valid) begin
        check_eq("toggle_pc", 64'(bus.id_reg_pc), 64'(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    check_eq("toggle_count", 64'(exp_pc), 64'h210);

    // PC wrap at the top of the address space.
    bus.memory_i_ready = 1'b1;
    bus.id_ready       = 1'b0;
    br_flg             = 1'b1;
    br_target          = 32'hFFFF_FFFC;
    tick();
    br_flg = 1'b0;
    settle();
    check_eq("wrap_addr_top", 64'(bus.memory_i_addr), 64'hFFFF_FFFC);
    tick();
    settle();
    check_eq("wrap_addr_zero", 64'(bus.memory_i_addr), 64'h0);
    tick();
    settle();
    check_eq("wrap_head_pc",   64'(bus.id_reg_pc), 64'hFFFF_FFFC);
    check_eq("wrap_occupancy", 64'(occupancy), 64'd2);
    bus.id_ready = 1'b1;
    tick();
    settle();
    check_eq("wrap_next_pc", 64'(bus.id_reg_pc), 64'h0);

    // Reset mid-stream discards queued entries.
    bus.id_ready = 1'b0;
    reset        = 1'b1;
    settle();
    check_eq("mid_rst_id_valid", 64'(bus.id_valid), 64'd0);
    tick();
    reset              = 1'b0;
    bus.memory_i_ready = 1'b0;
    settle();
    check_eq("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("mid_rst_id_valid2", 64'(bus.id_valid), 64'd0);
    check_eq("mid_rst_addr",      64'(bus.memory_i_addr), 64'h0);
    check_eq("mid_rst_mem_valid", 64'(bus.memory_i_valid), 64'd1);
`else
    // Bypass: empty queue, response reaches decode in the same cycle.
    reset  = 1'b0;
    br_flg = 1'b0;
    settle();
    check_eq("byp_id_valid",  64'(bus.id_valid), 64'd1);
    check_eq("byp_id_pc",     64'(bus.id_reg_pc), 64'h0);
    check_eq("byp_id_inst",   64'(bus.id_inst), 64'(mem_model(32'h0)));
    check_eq("byp_occupancy", 64'(occupancy), 64'd0);
    tick();
    settle();
    check_eq("byp_occ_after", 64'(occupancy), 64'd0);
    check_eq("byp_pc_after",  64'(bus.id_reg_pc), 64'h4);
    bus.id_ready = 1'b0;
    settle();
    check_eq("byp_hold_valid", 64'(bus.id_valid), 64'd1);
    tick();
    settle();
    check_eq("byp_hold_occ",  64'(occupancy), 64'd1);
    check_eq("byp_hold_pc",   64'(bus.id_reg_pc), 64'h4);
    check_eq("byp_hold_addr", 64'(bus.memory_i_addr), 64'h8);
    bus.id_ready = 1'b1;
    tick();
    settle();
    check_eq("byp_drain_pc",  64'(bus.id_reg_pc), 64'h8);
    check_eq("byp_drain_occ", 64'(occupancy), 64'd1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_inst_fetch_queue
